data_mem_responder: RTL and testbench

- Data-memory responder: the other end of the load/store interface driven by the processor's MEM stage (mem_read / mem_write).
- Accepts one word request at a time and inserts a configurable number of wait states, signalled back to the pipeline through stall.
- Returns load data with a one-cycle rvalid pulse, commits stores, and flags illegal requests.
- Instantiated beside the processor top; replaces the ideal single-cycle data memory.

---
 rtl/mem_resp_pkg.sv | 12 +
 rtl/data_mem_array.sv | 24 ++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and helpers for the data-memory responder
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  localparam int WORD_BYTES = 4;

  function automatic int idx_width(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port word memory, synchronous write, registered read
module data_mem_array
  import mem_resp_pkg::*;
#(
  parameter int Bits    = 32,
  parameter int MemSize = 64,
  parameter int IW      = idx_width(MemSize)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [IW-1:0]   idx,
  input  logic [Bits-1:0] wdata,
  output logic [Bits-1:0] rdata
);

  logic [Bits-1:0] mem [MemSize];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder with programmable wait states
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int Bits    = 32,
  parameter int MemSize = 64,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [Bits-1:0] addr,
  input  logic [Bits-1:0] wdata,
  output logic [Bits-1:0] rdata,
  output logic            rvalid,
  output logic            stall,
  output logic            err
);

  localparam int IW  = idx_width(MemSize);
  localparam int OFS = $clog2(WORD_BYTES);

  resp_state_t     state;
  logic [3:0]      cnt;
  logic            op_write;
  logic [IW-1:0]   idx_q;
  logic [Bits-1:0] wdata_q;
  logic            loaded;

  logic            req;
  logic            illegal;
  logic            enter_resp;
  logic            acc_write;
  logic            we;
  logic            re;
  logic [IW-1:0]   acc_idx;
  logic [Bits-1:0] acc_wdata;
  logic [Bits-1:0] arr_rdata;
  logic [Bits-1:0] word;

  assign req     = mem_read | mem_write;
  assign word    = addr >> OFS;
  assign illegal = (addr[OFS-1:0] != '0) || (word >= Bits'(MemSize)) || (mem_read & mem_write);

  // In IDLE the access (LATENCY=1 only) uses live inputs; afterwards the latched copy.
  always_comb begin
    stall      = 1'b0;
    enter_resp = 1'b0;
    acc_idx    = idx_q;
    acc_write  = op_write;
    acc_wdata  = wdata_q;
    case (state)
      IDLE: begin
        stall      = req;
        acc_idx    = word[IW-1:0];
        acc_write  = mem_write;
        acc_wdata  = wdata;
        enter_resp = req && !illegal && (LATENCY == 1);
      end
      WAIT: begin
        stall      = 1'b1;
        enter_resp = (cnt == 4'd0);
      end
      default: ;
    endcase
  end

  // Reset on the RESP-entry edge suppresses both the commit and the load.
  assign we = enter_resp & acc_write & ~rst;
  assign re = enter_resp & ~acc_write & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rvalid <= 1'b0;
      err    <= 1'b0;
      loaded <= 1'b0;
    end else begin
      rvalid <= re;
      err    <= 1'b0;
      if (re) loaded <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q    <= word[IW-1:0];
            wdata_q  <= wdata;
            op_write <= mem_write;
            if (illegal) begin
              state <= RESP;
              err   <= 1'b1;
            end else if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  data_mem_array #(
    .Bits    (Bits),
    .MemSize (MemSize),
    .IW      (IW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // The array read register has no reset, so rdata reads as zero until the first load.
  assign rdata = loaded ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized bench against a transaction-level memory model
module tb_data_mem_responder;

  typedef struct packed {
    logic        chk;
    logic        stall;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 5);

    logic        rst = 1'b1;
    logic        rd  = 1'b0;
    logic        wr  = 1'b0;
    logic [31:0] a   = '0;
    logic [31:0] wd  = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        err;
    logic        done = 1'b0;

    logic [31:0] mem_m [64];
    logic [31:0] rdata_m = '0;
    exp_t        q[$];
    exp_t        e;
    logic [31:0] last_load;
    int          stall_run = 0;
    int          last_stall_run = 0;

    data_mem_responder #(
      .Bits    (32),
      .MemSize (64),
      .LATENCY (LAT)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (rd),
      .mem_write (wr),
      .addr      (a),
      .wdata     (wd),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .stall     (stall),
      .err       (err)
    );

    initial forever begin
      @(negedge clk);
      if (stall === 1'b1) stall_run++;
      else if (stall_run != 0) begin
        last_stall_run = stall_run;
        stall_run = 0;
      end
      if (rvalid === 1'b1) last_load = rdata;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check($sformatf("lat%0d stall", LAT), 32'(stall), 32'(e.stall));
          check($sformatf("lat%0d rvalid", LAT), 32'(rvalid), 32'(e.rvalid));
          check($sformatf("lat%0d err", LAT), 32'(err), 32'(e.err));
          check($sformatf("lat%0d rdata", LAT), rdata, e.rdata);
        end
      end
    end

    function automatic bit legal(input logic r, input logic w, input logic [31:0] ad);
      return (ad[1:0] == 2'b00) && (ad < 32'd256) && !(r && w);
    endfunction

    task automatic step(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d,
                        input logic rs, input logic es, input logic ev, input logic ee, input logic ch);
      rd  = r;
      wr  = w;
      a   = ad;
      wd  = d;
      rst = rs;
      q.push_back(exp_t'{ch, es, ev, ee, rdata_m});
      @(posedge clk);
      #1;
    endtask

    task automatic idle();
      step(1'b0, 1'b0, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic req(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d);
      if (!legal(r, w, ad)) begin
        step(r, w, ad, d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(r, w, ad, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      end else begin
        for (int i = 0; i < LAT; i++) begin
          if (i == 0) step(r, w, ad, d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
          else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        if (w) mem_m[ad[7:2]] = d;
        else rdata_m = mem_m[ad[7:2]];
        step(r, w, ad, d, 1'b0, 1'b0, r, 1'b0, 1'b1);
      end
    endtask

    // rst lands on stall cycle k of the request; the access never happens.
    task automatic abort_req(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] d,
                             input int k);
      for (int i = 0; i < k; i++) step(r, w, ad, d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(r, w, ad, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      rdata_m = '0;
    endtask

    initial begin
      logic [31:0] ad;
      int unsigned o;
      int unsigned s;
      @(posedge clk);
      #1;
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rdata_m = '0;
      repeat (5) idle();

      for (int i = 0; i < 64; i++) req(1'b0, 1'b1, 32'(i * 4), $urandom());

      req(1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
      check($sformatf("lat%0d store_stall_cycles", LAT), 32'(last_stall_run), 32'(LAT));
      req(1'b1, 1'b0, 32'h8, $urandom());
      check($sformatf("lat%0d load_stall_cycles", LAT), 32'(last_stall_run), 32'(LAT));
      check($sformatf("lat%0d load_0x8", LAT), last_load, 32'hDEADBEEF);

      req(1'b1, 1'b0, 32'h6, '0);
      check($sformatf("lat%0d misaligned_stall", LAT), 32'(last_stall_run), 32'd1);
      req(1'b1, 1'b0, 32'(64 * 4), '0);
      req(1'b1, 1'b1, 32'h8, 32'h0BAD0BAD);
      req(1'b0, 1'b1, 32'h6, 32'h0BAD0BAD);
      req(1'b1, 1'b0, 32'h8, '0);
      check($sformatf("lat%0d mem_unchanged", LAT), last_load, 32'hDEADBEEF);

      req(1'b0, 1'b1, 32'h0, 32'd1);
      req(1'b0, 1'b1, 32'h4, 32'd2);
      req(1'b0, 1'b1, 32'h8, 32'd3);
      req(1'b1, 1'b0, 32'h0, '0);
      req(1'b1, 1'b0, 32'h4, '0);
      req(1'b1, 1'b0, 32'h8, '0);
      check($sformatf("lat%0d b2b_last", LAT), last_load, 32'd3);

      req(1'b0, 1'b1, 32'h10, 32'h1234);
      abort_req(1'b0, 1'b1, 32'h10, 32'h55, (LAT > 1) ? 1 : 0);
      idle();
      req(1'b1, 1'b0, 32'h10, '0);
      check($sformatf("lat%0d abort_wait", LAT), last_load, 32'h1234);
      abort_req(1'b0, 1'b1, 32'h10, 32'h77, LAT - 1);
      idle();
      req(1'b1, 1'b0, 32'h10, '0);
      check($sformatf("lat%0d abort_resp_edge", LAT), last_load, 32'h1234);

      for (int n = 0; n < 300; n++) begin
        o  = $urandom_range(0, 9);
        s  = $urandom_range(0, 99);
        ad = 32'($urandom_range(0, 63)) << 2;
        if (s < 8) ad = $urandom();
        else if (s < 16) ad[1:0] = 2'($urandom_range(1, 3));
        else if (s < 22) ad = 32'($urandom_range(64, 1000)) << 2;
        if (o < 2) idle();
        else if (o < 6) req(1'b1, 1'b0, ad, $urandom());
        else if (o < 9) req(1'b0, 1'b1, ad, $urandom());
        else req(1'b1, 1'b1, ad, $urandom());
      end

      idle();
      idle();
      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].done && lane[1].done && lane[2].done);
      begin
        #1000000;
        miscompares++;
        $display("FAIL timeout: lanes not done by time limit");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
